// File: rtl/link_pkg.sv
// Shared definitions for the LVDS link framer (transmit) and bitslip aligner (receive).
// Both ends take their training-word default from here, so they always agree.
package link_pkg;

  localparam int WORD_W      = 16;
  localparam int TRAIN_CNT_W = 10;

  localparam logic [WORD_W-1:0] LINK_TRAIN_PATTERN = 16'hff00;
  localparam logic [WORD_W-1:0] LINK_IDLE_PATTERN  = 16'h5a5a;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } link_state_t;

  function automatic logic [TRAIN_CNT_W-1:0] sat_inc(input logic [TRAIN_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// 16-bit MSB-first serializer with a free-running slot counter.
// A new word is loaded on the last bit cycle of every slot; the slot phase restarts at reset.
module word_serializer
  import link_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_WORD = LINK_IDLE_PATTERN
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic [WORD_W-1:0] next_word,
  output logic              boundary,
  output logic              word_sync,
  output logic              ser_out
);

  logic [WORD_W-1:0] shreg;
  logic [3:0]        bit_cnt;

  assign boundary  = (bit_cnt == 4'd15);
  assign word_sync = (bit_cnt == 4'd0);
  assign ser_out   = shreg[WORD_W-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 4'd0;
      shreg   <= RESET_WORD;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
      if (boundary) begin
        shreg <= next_word;
      end else begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/link_train_tx.sv
// Transmit-side link framer: IDLE/TRAIN/DATA sequencing and word selection per slot,
// feeding a word_serializer that shifts each 16-bit word out MSB first.
module link_train_tx
  import link_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = LINK_TRAIN_PATTERN,
  parameter logic [WORD_W-1:0] IDLE_PATTERN  = LINK_IDLE_PATTERN,
  parameter int                TRAIN_LEN     = 64
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              train_req,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              word_sync,
  output logic              link_up,
  output logic              train_done
);

  localparam logic [TRAIN_CNT_W-1:0] TRAIN_LEN_CNT = TRAIN_CNT_W'(TRAIN_LEN);

  link_state_t             state, state_next;
  logic [TRAIN_CNT_W-1:0]  train_cnt, train_cnt_next;
  logic [WORD_W-1:0]       next_word;
  logic                    boundary;
  logic                    train_exit;
  logic                    data_word_ok;

  word_serializer #(
    .RESET_WORD (IDLE_PATTERN)
  ) u_serializer (
    .fclk      (fclk),
    .rst       (rst),
    .next_word (next_word),
    .boundary  (boundary),
    .word_sync (word_sync),
    .ser_out   (ser_out)
  );

  // Training ends only once the minimum burst is sent and the request has dropped.
  assign train_exit   = (train_cnt >= TRAIN_LEN_CNT) && !train_req;
  assign data_word_ok = (state == ST_DATA) || ((state == ST_TRAIN) && train_exit);
  assign tx_ready     = boundary && data_word_ok && !train_req;
  assign train_done   = boundary && (state == ST_TRAIN) && train_exit;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    train_cnt_next = train_cnt;
    next_word      = IDLE_PATTERN;

    unique case (state)
      ST_IDLE: begin
        if (train_req) begin
          state_next     = ST_TRAIN;
          train_cnt_next = TRAIN_CNT_W'(1);
          next_word      = TRAIN_PATTERN;
        end
      end

      ST_TRAIN: begin
        if (train_exit) begin
          state_next = ST_DATA;
          next_word  = tx_valid ? tx_data : IDLE_PATTERN;
        end else begin
          train_cnt_next = sat_inc(train_cnt);
          next_word      = TRAIN_PATTERN;
        end
      end

      ST_DATA: begin
        if (train_req) begin
          state_next     = ST_TRAIN;
          train_cnt_next = TRAIN_CNT_W'(1);
          next_word      = TRAIN_PATTERN;
        end else begin
          next_word = tx_valid ? tx_data : IDLE_PATTERN;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM, burst counter and link_up only move at slot boundaries.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      train_cnt <= '0;
      link_up   <= 1'b0;
    end else if (boundary) begin
      state     <= state_next;
      train_cnt <= train_cnt_next;
      link_up   <= (state_next == ST_DATA);
    end
  end

  a_ready_at_boundary : assert property (@(posedge fclk) disable iff (rst)
    tx_ready |-> boundary);

  a_done_implies_ready : assert property (@(posedge fclk) disable iff (rst)
    train_done |-> tx_ready);

  a_link_up_matches_state : assert property (@(posedge fclk) disable iff (rst)
    link_up == (state == ST_DATA));

endmodule

// File: tb/tb_link_train_tx.sv
// Directed bench for link_train_tx with TRAIN_LEN=4: reset, idle fill, training bursts,
// payload streaming, request priority over payload and reset in the middle of a training word.
module tb_link_train_tx;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic        train_req = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        ser_out;
  logic        word_sync;
  logic        link_up;
  logic        train_done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] w;
  int          ws_err, rdy_cnt, rdy_pos, done_cnt;
  logic        lu0;

  link_train_tx #(
    .TRAIN_PATTERN (16'hff00),
    .IDLE_PATTERN  (16'h5a5a),
    .TRAIN_LEN     (4)
  ) dut (
    .fclk       (fclk),
    .rst        (rst),
    .train_req  (train_req),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ser_out    (ser_out),
    .word_sync  (word_sync),
    .link_up    (link_up),
    .train_done (train_done)
  );

  always #5 fclk = ~fclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Collects one 16-cycle slot starting at the word_sync cycle. Inputs are driven
  // on each falling edge: req_bits[i] is train_req during bit cycle i of the slot.
  task automatic read_slot(input logic [15:0] req_bits, input logic valid, input logic [15:0] data,
                           output logic [15:0] word, output int ws_errs, output int rdy,
                           output int rdy_at, output int done, output logic lu_first);
    word = '0; ws_errs = 0; rdy = 0; rdy_at = -1; done = 0; lu_first = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge fclk);
      train_req = req_bits[i];
      tx_valid  = valid;
      tx_data   = data;
      #1;
      word = {word[14:0], ser_out};
      if (word_sync !== (i == 0)) ws_errs++;
      if (tx_ready === 1'b1) begin rdy++; rdy_at = i; end
      if (train_done === 1'b1) done++;
      if (i == 0) lu_first = link_up;
    end
  endtask

  // Samples the reset state, releases reset and collects the rest of the first slot.
  task automatic release_and_read(output logic [15:0] word, output int ws_errs, output int rdy);
    word = {15'b0, ser_out};
    ws_errs = (word_sync === 1'b1) ? 0 : 1;
    rdy = 0;
    rst = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge fclk);
      #1;
      word = {word[14:0], ser_out};
      if (word_sync !== 1'b0) ws_errs++;
      if (tx_ready === 1'b1) rdy++;
    end
  endtask

  task automatic test_reset;
    logic [4:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge fclk);
    #1;
    outs = {ser_out, word_sync, tx_ready, link_up, train_done};
    vectors++;
    if (outs !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_outputs {ser,sync,rdy,up,done} got %b want 01000", outs);
    end
    release_and_read(w, ws_err, rdy_cnt);
    vectors++;
    if (w !== 16'h5a5a || ws_err != 0 || rdy_cnt != 0) begin
      miscompares++;
      $display("FAIL first_slot_after_reset word %h sync_err %0d rdy %0d want 5a5a/0/0", w, ws_err, rdy_cnt);
    end
  endtask

  task automatic test_idle;
    for (int s = 0; s < 2; s++) begin
      read_slot(16'h0000, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
      vectors++;
      if (w !== 16'h5a5a || ws_err != 0 || rdy_cnt != 0 || lu0 !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_slot%0d word %h sync_err %0d rdy %0d up %b want 5a5a/0/0/0", s, w, ws_err, rdy_cnt, lu0);
      end
    end
  endtask

  task automatic test_train_pulse;
    // train_req high only in the boundary cycle of an idle slot
    read_slot(16'h8000, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'h5a5a || rdy_cnt != 0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL pulse_slot word %h rdy %0d done %0d want 5a5a/0/0", w, rdy_cnt, done_cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      read_slot(16'h0000, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
      vectors++;
      if (w !== 16'hff00 || ws_err != 0 || lu0 !== 1'b0) begin
        miscompares++;
        $display("FAIL train_word%0d word %h sync_err %0d up %b want ff00/0/0", k, w, ws_err, lu0);
      end
      vectors++;
      if (rdy_cnt != ((k == 4) ? 1 : 0) || done_cnt != ((k == 4) ? 1 : 0) ||
          (k == 4 && rdy_pos != 15)) begin
        miscompares++;
        $display("FAIL train_exit%0d rdy %0d at %0d done %0d want %0d/%0d", k, rdy_cnt, rdy_pos, done_cnt,
                 (k == 4) ? 1 : 0, (k == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_data_stream;
    logic [15:0] exp_word [5] = '{16'h5a5a, 16'h5a5a, 16'h1234, 16'h1234, 16'hff00};
    logic        vld      [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] dat      [5] = '{16'h0000, 16'h1234, 16'h1234, 16'hff00, 16'h0000};
    for (int s = 0; s < 5; s++) begin
      read_slot(16'h0000, vld[s], dat[s], w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
      vectors++;
      if (w !== exp_word[s] || lu0 !== 1'b1 || ws_err != 0) begin
        miscompares++;
        $display("FAIL data_slot%0d word %h up %b sync_err %0d want %h/1/0", s, w, lu0, ws_err, exp_word[s]);
      end
      vectors++;
      if (rdy_cnt != 1 || rdy_pos != 15 || done_cnt != 0) begin
        miscompares++;
        $display("FAIL data_ready%0d rdy %0d at %0d done %0d want 1/15/0", s, rdy_cnt, rdy_pos, done_cnt);
      end
    end
  endtask

  task automatic test_req_priority;
    read_slot(16'hffff, 1'b1, 16'hbeef, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'h5a5a || rdy_cnt != 0 || lu0 !== 1'b1) begin
      miscompares++;
      $display("FAIL priority_slot word %h rdy %0d up %b want 5a5a/0/1", w, rdy_cnt, lu0);
    end
    for (int k = 1; k <= 4; k++) begin
      read_slot(16'h0000, 1'b1, 16'hbeef, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
      vectors++;
      if (w !== 16'hff00 || lu0 !== 1'b0 || rdy_cnt != ((k == 4) ? 1 : 0) || done_cnt != ((k == 4) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL retrain_word%0d word %h up %b rdy %0d done %0d want ff00/0/%0d/%0d", k, w, lu0, rdy_cnt,
                 done_cnt, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0);
      end
    end
    read_slot(16'h0000, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'hbeef || lu0 !== 1'b1) begin
      miscompares++;
      $display("FAIL held_payload word %h up %b want beef/1", w, lu0);
    end
  endtask

  task automatic test_train_held;
    int n_train;
    read_slot(16'hffff, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'h5a5a || rdy_cnt != 0 || lu0 !== 1'b1) begin
      miscompares++;
      $display("FAIL held_entry word %h rdy %0d up %b want 5a5a/0/1", w, rdy_cnt, lu0);
    end
    n_train = 0;
    for (int k = 1; k <= 10; k++) begin
      read_slot((k < 10) ? 16'hffff : 16'h0000, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
      if (w === 16'hff00 && lu0 === 1'b0) n_train++;
      if (k < 10) begin
        vectors++;
        if (rdy_cnt != 0 || done_cnt != 0) begin
          miscompares++;
          $display("FAIL held_no_exit%0d rdy %0d done %0d want 0/0", k, rdy_cnt, done_cnt);
        end
      end else begin
        vectors++;
        if (rdy_cnt != 1 || done_cnt != 1) begin
          miscompares++;
          $display("FAIL held_exit rdy %0d done %0d want 1/1", rdy_cnt, done_cnt);
        end
      end
    end
    vectors++;
    if (n_train != 10) begin
      miscompares++;
      $display("FAIL held_train_count got %0d want 10", n_train);
    end
    read_slot(16'h0000, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'h5a5a || lu0 !== 1'b1) begin
      miscompares++;
      $display("FAIL held_after word %h up %b want 5a5a/1", w, lu0);
    end
  endtask

  task automatic test_reset_mid_train;
    logic [4:0] outs;
    logic [7:0] part;
    // request raised mid-slot: takes effect at this slot's boundary
    read_slot(16'hff00, 1'b0, 16'h0000, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'h5a5a || rdy_cnt != 0 || lu0 !== 1'b1) begin
      miscompares++;
      $display("FAIL midreq_slot word %h rdy %0d up %b want 5a5a/0/1", w, rdy_cnt, lu0);
    end
    part = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge fclk);
      train_req = 1'b0;
      #1;
      part = {part[6:0], ser_out};
    end
    vectors++;
    if (part !== 8'hff) begin
      miscompares++;
      $display("FAIL train_before_reset bits %h want ff", part);
    end
    rst = 1'b1;
    #1;
    outs = {ser_out, word_sync, tx_ready, link_up, train_done};
    vectors++;
    if (outs !== 5'b01000) begin
      miscompares++;
      $display("FAIL async_reset_outputs {ser,sync,rdy,up,done} got %b want 01000", outs);
    end
    repeat (3) @(negedge fclk);
    #1;
    release_and_read(w, ws_err, rdy_cnt);
    vectors++;
    if (w !== 16'h5a5a || ws_err != 0 || rdy_cnt != 0) begin
      miscompares++;
      $display("FAIL slot_after_midreset word %h sync_err %0d rdy %0d want 5a5a/0/0", w, ws_err, rdy_cnt);
    end
    read_slot(16'h0000, 1'b1, 16'h1234, w, ws_err, rdy_cnt, rdy_pos, done_cnt, lu0);
    vectors++;
    if (w !== 16'h5a5a || rdy_cnt != 0 || lu0 !== 1'b0 || ws_err != 0) begin
      miscompares++;
      $display("FAIL idle_after_midreset word %h rdy %0d up %b sync_err %0d want 5a5a/0/0/0", w, rdy_cnt, lu0, ws_err);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_train_pulse();
    test_data_stream();
    test_req_priority();
    test_train_held();
    test_reset_mid_train();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
